// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 UART receiver plus loader that writes 16 bytes after a sync byte into CPU RAM.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       prog,
  output logic [3:0] addr,
  output logic [7:0] data,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {WAIT_SYNC, LOAD} ld_state_t;
  logic rx_s1, rx_s2;
  rx_state_t rs, rs_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sr, sr_n;
  logic byte_valid, bv_n, frame_err, fe_n;
  ld_state_t ls, ls_n;
  logic [3:0] cnt4, cnt4_n, addr_n;
  logic [7:0] data_n;
  logic prog_n, err_n, last, hold_n, done_n;
  assign busy = rs != R_IDLE;
  always_comb begin
    rs_n = rs;
    cnt_n = cnt + 1'b1;
    bit_n = bit_idx;
    sr_n = sr;
    bv_n = 1'b0;
    fe_n = 1'b0;
    case (rs)
      R_IDLE: begin
        cnt_n = '0;
        rs_n = rx_s2 ? R_IDLE : R_START;
      end
      R_START: if (cnt == HALF) begin
        cnt_n = '0;
        bit_n = '0;
        rs_n = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sr_n = {rx_s2, sr[7:1]};
        bit_n = bit_idx + 1'b1;
        rs_n = (bit_idx == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt == LAST) begin
        cnt_n = '0;
        rs_n = R_IDLE;
        bv_n = rx_s2;
        fe_n = !rx_s2;
      end
      default: rs_n = R_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rs <= R_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sr <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rs <= rs_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sr <= sr_n;
      byte_valid <= bv_n;
      frame_err <= fe_n;
    end
  end
  // cpu_hold stays up through the final write; done follows one cycle after it
  always_comb begin
    ls_n = ls;
    cnt4_n = cnt4;
    prog_n = 1'b0;
    addr_n = addr;
    data_n = data;
    err_n = error;
    last = 1'b0;
    case (ls)
      WAIT_SYNC: if (byte_valid && sr == SYNC_BYTE) begin
        ls_n = LOAD;
        cnt4_n = '0;
        err_n = 1'b0;
      end
      LOAD: if (frame_err) begin
        ls_n = WAIT_SYNC;
        err_n = 1'b1;
      end else if (byte_valid) begin
        prog_n = 1'b1;
        addr_n = cnt4;
        data_n = sr;
        cnt4_n = cnt4 + 1'b1;
        last = cnt4 == 4'hF;
        ls_n = last ? WAIT_SYNC : LOAD;
      end
      default: ls_n = WAIT_SYNC;
    endcase
    hold_n = (ls_n == LOAD) || last;
    done_n = prog && addr == 4'hF && cpu_hold;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ls <= WAIT_SYNC;
      cnt4 <= '0;
      prog <= 1'b0;
      addr <= '0;
      data <= '0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      ls <= ls_n;
      cnt4 <= cnt4_n;
      prog <= prog_n;
      addr <= addr_n;
      data <= data_n;
      cpu_hold <= hold_n;
      done <= done_n;
      error <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed UART load scenarios with a write monitor and hand-computed expectations.
module tb_uart_prog_loader;
  logic clk = 0, reset = 1, rx = 1;
  logic prog, cpu_hold, done, error, busy;
  logic [3:0] addr;
  logic [7:0] data;
  int errs = 0, checks = 0;
  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int done_cnt = 0, dbl = 0, hold_bad = 0, done_bad = 0, busy_cnt = 0;
  logic prev_prog = 0;
  int w0, d0;

  uart_prog_loader #(.CLKS_PER_BIT(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .prog(prog), .addr(addr), .data(data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog) begin
      wa.push_back(addr);
      wd.push_back(data);
      if (!cpu_hold) hold_bad++;
    end
    if (prog && prev_prog) dbl++;
    if (done && (cpu_hold || !prev_prog)) done_bad++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    prev_prog = prog;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop_bit;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic mark;
    w0 = wa.size();
    d0 = done_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    mark();
    repeat (500) @(negedge clk);
    chk("idle_writes", wa.size() - w0, 0);
    chk("idle_prog", prog, 0);
    chk("idle_addr", addr, 0);
    chk("idle_data", data, 0);
    chk("idle_hold", cpu_hold, 0);
    chk("idle_done", done_cnt - d0, 0);
    chk("idle_error", error, 0);
    chk("idle_busy", busy_cnt, 0);

    mark();
    send_byte(8'h3C);
    chk("nosync_writes", wa.size() - w0, 0);
    chk("nosync_hold", cpu_hold, 0);

    mark();
    send_byte(8'hA5);
    chk("sync_hold", cpu_hold, 1);
    for (int n = 0; n < 16; n++) send_byte(8'(n));
    chk("full_writes", wa.size() - w0, 16);
    for (int n = 0; n < 16; n++) begin
      chk("full_addr", wa[w0 + n], 32'(n));
      chk("full_data", wd[w0 + n], 32'(n));
    end
    chk("full_done", done_cnt - d0, 1);
    chk("full_hold_end", cpu_hold, 0);

    mark();
    send_byte(8'hA5);
    send_byte(8'h21);
    send_byte(8'h42);
    send_byte(8'h63);
    send_byte(8'hFF, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_writes", wa.size() - w0, 3);
    chk("ferr_data2", wd[w0 + 2], 8'h63);
    chk("ferr_error", error, 1);
    chk("ferr_hold", cpu_hold, 0);
    chk("ferr_done", done_cnt - d0, 0);

    mark();
    send_byte(8'hA5);
    chk("resync_error", error, 0);
    for (int n = 0; n < 16; n++) send_byte(8'(8'hF0 - n));
    chk("reload_writes", wa.size() - w0, 16);
    chk("reload_a15", wa[w0 + 15], 15);
    chk("reload_d15", wd[w0 + 15], 8'hE1);
    chk("reload_done", done_cnt - d0, 1);
    chk("reload_hold", cpu_hold, 0);

    mark();
    send_byte(8'hA5);
    send_byte(8'hA5);
    chk("syncdata_writes", wa.size() - w0, 1);
    chk("syncdata_addr", wa[w0], 0);
    chk("syncdata_data", wd[w0], 8'hA5);
    chk("syncdata_hold", cpu_hold, 1);

    busy_cnt = 0;
    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_seen", busy_cnt > 0, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_error", error, 0);
    send_byte(8'h11);
    chk("glitch_writes", wa.size() - w0, 2);
    chk("glitch_addr", wa[w0 + 1], 1);
    chk("glitch_data", wd[w0 + 1], 8'h11);

    reset = 1;
    @(negedge clk);
    reset = 0;
    mark();
    send_byte(8'hA5);
    for (int n = 0; n < 7; n++) send_byte(8'(n + 8'h30));
    fork
      send_byte(8'h07);
      begin
        repeat (40) @(negedge clk);
        chk("rst_hold_before", cpu_hold, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_hold_after", cpu_hold, 0);
        chk("rst_busy_after", busy, 0);
      end
    join
    repeat (120) @(negedge clk);
    chk("rst_writes", wa.size() - w0, 7);
    chk("rst_last_data", wd[w0 + 6], 8'h36);
    chk("rst_done", done_cnt - d0, 0);
    chk("rst_hold_end", cpu_hold, 0);

    chk("double_prog", dbl, 0);
    chk("hold_at_prog", hold_bad, 0);
    chk("done_timing", done_bad, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
